// File: rtl/uart_receive.sv
// uart_receive: 8N1 serial receiver with an internal bit-rate counter.
// RXD is synchronised, the start bit is qualified at mid-bit, and data and
// stop bits are sampled at their centres. Good frames update DATA with a
// DATA_READY pulse; a low stop bit gives one FRAME_ERR pulse and the receiver
// then waits for the line to return high.
module uart_receive #(
  parameter int unsigned CLKS_PER_BIT = 26,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RXD,
  output logic [7:0] DATA,
  output logic       DATA_READY,
  output logic       FRAME_ERR,
  output logic       BUSY
);

  localparam int unsigned HALF = CLKS_PER_BIT / 2;
  localparam int unsigned CW   = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rxs;
  logic [CW-1:0]          clk_cnt;
  logic [3:0]             bit_idx;
  logic [7:0]             shift;
  logic                   tick;

  // RXD synchroniser, preset to the idle (high) line level
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) sync <= '1;
    else      sync <= {sync[SYNC_STAGES-2:0], RXD};
  end

  assign rxs = sync[SYNC_STAGES-1];

  // FSM state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (!rxs) state_nxt = S_START;
      S_START:     if (tick) state_nxt = rxs ? S_IDLE : S_DATA;
      S_DATA:      if (tick && bit_idx == 4'd7) state_nxt = S_STOP;
      S_STOP:      if (tick) state_nxt = rxs ? S_IDLE : S_WAIT_HIGH;
      S_WAIT_HIGH: if (rxs) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Output decode: busy flag and sample-point tick for the current state
  always_comb begin
    tick = 1'b0;
    BUSY = (state != S_IDLE);
    case (state)
      S_START:        tick = (clk_cnt == HALF_END);
      S_DATA, S_STOP: tick = (clk_cnt == BIT_END);
      default:        tick = 1'b0;
    endcase
  end

  // Bit timing, shift register, output byte and result strobes
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      clk_cnt    <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      DATA       <= '0;
      DATA_READY <= 1'b0;
      FRAME_ERR  <= 1'b0;
    end else begin
      DATA_READY <= 1'b0;
      FRAME_ERR  <= 1'b0;
      case (state)
        S_START: begin
          bit_idx <= '0;
          clk_cnt <= tick ? '0 : clk_cnt + 1'b1;
        end
        S_DATA: begin
          if (tick) begin
            clk_cnt <= '0;
            shift   <= {rxs, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (tick) begin
            clk_cnt <= '0;
            if (rxs) begin
              DATA       <= shift;
              DATA_READY <= 1'b1;
            end else begin
              FRAME_ERR  <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: begin
          clk_cnt <= '0;
          bit_idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receive.sv
// Bench for uart_receive: directed scenarios plus randomised frames, checked
// against a frame-level model (queue of expected good bytes / framing errors).
`timescale 1ns/1ps
module tb_uart_receive;

  localparam int unsigned CPB  = 26;
  localparam int unsigned SYNC = 2;
  // RXD fall (driven after edge N) to DATA_READY visible (after edge N+LAT):
  // SYNC edges to reach rxs, one edge to leave IDLE, half a bit to the start
  // centre, nine bit times to the stop centre.
  localparam int unsigned LAT  = SYNC + 1 + CPB / 2 + 9 * CPB;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RXD;
  logic [7:0] DATA;
  logic       DATA_READY;
  logic       FRAME_ERR;
  logic       BUSY;

  uart_receive #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RXD        (RXD),
    .DATA       (DATA),
    .DATA_READY (DATA_READY),
    .FRAME_ERR  (FRAME_ERR),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic       err;
    logic [7:0] b;
  } ev_t;

  ev_t         exp_q[$];
  logic [7:0]  last_good   = 8'h00;
  int unsigned dr_count    = 0;
  int unsigned fe_count    = 0;
  int unsigned last_dr_cyc = 0;
  int unsigned start_cyc   = 0;
  int          n_checks    = 0;
  int          n_errors    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic hold(input logic v, input int unsigned n);
    RXD = v;
    repeat (n) @(negedge CLK);
  endtask

  task automatic send(input logic [7:0] b, input logic stop, input int unsigned per);
    ev_t e;
    e.err = ~stop;
    e.b   = b;
    exp_q.push_back(e);
    start_cyc = cyc;
    hold(1'b0, per);
    for (int i = 0; i < 8; i++) hold(b[i], per);
    hold(stop, per);
  endtask

  // Strobe monitor: every pulse must match the next expected frame outcome
  always @(negedge CLK) begin
    ev_t  e;
    logic prev_dr;
    if (!RST) begin
      last_good = 8'h00;
      prev_dr   = 1'b0;
    end else begin
      if (DATA_READY || FRAME_ERR)
        check_eq("strobe_excl", DATA_READY & FRAME_ERR, 0);
      if (DATA_READY) begin
        check_eq("dr_width", prev_dr, 0);
        dr_count++;
        last_dr_cyc = cyc;
        check_eq("dr_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("dr_kind", e.err, 0);
          check_eq("dr_data", DATA, e.b);
          last_good = e.b;
        end
      end else if (FRAME_ERR) begin
        fe_count++;
        check_eq("fe_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("fe_kind", e.err, 1);
          check_eq("fe_data_held", DATA, last_good);
        end
      end
      prev_dr = DATA_READY;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned dr0, fe0, per, gap;
    logic [7:0]  b;
    logic        stop;

    RST = 1'b0;
    RXD = 1'b1;
    repeat (4) @(negedge CLK);
    check_eq("rst_data", DATA, 8'h00);
    check_eq("rst_dr", DATA_READY, 0);
    check_eq("rst_fe", FRAME_ERR, 0);
    check_eq("rst_busy", BUSY, 0);
    RST = 1'b1;
    hold(1'b1, 2 * CPB);

    // 0x55 after idle: exact latency, BUSY released after the pulse
    send(8'h55, 1'b1, CPB);
    check_eq("t1_count", dr_count, 1);
    check_eq("t1_latency", last_dr_cyc - start_cyc, LAT);
    check_eq("t1_data", DATA, 8'h55);
    @(negedge CLK);
    check_eq("t1_busy_low", BUSY, 0);
    hold(1'b1, CPB);

    // Short low glitch is rejected at the start-bit centre
    dr0 = dr_count;
    fe0 = fe_count;
    hold(1'b0, 5);
    hold(1'b1, 3);
    check_eq("t2_busy_high", BUSY, 1);
    hold(1'b1, 11);
    check_eq("t2_busy_low", BUSY, 0);
    hold(1'b1, CPB);
    check_eq("t2_no_dr", dr_count, dr0);
    check_eq("t2_no_fe", fe_count, fe0);

    // Bad stop bit then stuck-low line: single FRAME_ERR, DATA held
    fe0 = fe_count;
    dr0 = dr_count;
    send(8'hA3, 1'b0, CPB);
    hold(1'b0, 2600);
    check_eq("t3_fe_once", fe_count, fe0 + 1);
    check_eq("t3_busy_wait", BUSY, 1);
    check_eq("t3_data_held", DATA, 8'h55);
    hold(1'b1, 2 * CPB);
    check_eq("t3_busy_idle", BUSY, 0);
    send(8'h01, 1'b1, CPB);
    hold(1'b1, CPB);
    check_eq("t3_next_data", DATA, 8'h01);
    check_eq("t3_dr", dr_count, dr0 + 1);

    // Back-to-back frames without idle gap
    dr0 = dr_count;
    for (int i = 0; i < 10; i++) send(8'h30 + 8'(i), 1'b1, CPB);
    hold(1'b1, 2 * CPB);
    check_eq("t4_count", dr_count, dr0 + 10);
    check_eq("t4_last", DATA, 8'h39);

    // Reset during data bit 4 of 0xFF
    dr0 = dr_count;
    hold(1'b0, CPB);
    hold(1'b1, 4 * CPB + CPB / 2);
    #2 RST = 1'b0;
    @(negedge CLK);
    check_eq("t5_rst_data", DATA, 8'h00);
    check_eq("t5_rst_busy", BUSY, 0);
    check_eq("t5_rst_dr", DATA_READY, 0);
    hold(1'b1, 3);
    RST = 1'b1;
    hold(1'b1, 2 * CPB);
    check_eq("t5_no_partial", dr_count, dr0);
    send(8'h42, 1'b1, CPB);
    hold(1'b1, CPB);
    check_eq("t5_data", DATA, 8'h42);
    check_eq("t5_count", dr_count, dr0 + 1);

    // Bit period tolerance
    fe0 = fe_count;
    dr0 = dr_count;
    send(8'h96, 1'b1, CPB - 1);
    hold(1'b1, 2 * CPB);
    check_eq("t6_fast", DATA, 8'h96);
    send(8'h96, 1'b1, CPB + 1);
    hold(1'b1, 2 * CPB);
    check_eq("t6_slow", DATA, 8'h96);
    check_eq("t6_no_fe", fe_count, fe0);
    check_eq("t6_count", dr_count, dr0 + 2);

    // Randomised frames: data, stop validity, bit period and idle gap
    for (int i = 0; i < 40; i++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      per  = $urandom_range(CPB - 1, CPB + 1);
      send(b, stop, per);
      gap  = (stop && $urandom_range(0, 1) == 0) ? 0 : $urandom_range(CPB, 3 * CPB);
      hold(1'b1, gap);
    end
    hold(1'b1, 2 * CPB);

    check_eq("end_queue_empty", exp_q.size(), 0);
    check_eq("end_busy", BUSY, 0);
    check_eq("end_data", DATA, last_good);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
